// File: rtl/mlp_feature_loader.sv
// mlp_feature_loader: serial feature assembler, settle timer and result capture for a printed MLP regressor
module mlp_feature_loader #(
  parameter int N_FEAT        = 6,
  parameter int FEAT_W        = 5,
  parameter int OUT_W         = 20,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     feat_valid,
  input  logic [FEAT_W-1:0]        feat_data,
  output logic                     feat_ready,
  output logic [N_FEAT*FEAT_W-1:0] inp,
  input  logic [OUT_W-1:0]         mlp_out,
  output logic                     res_valid,
  output logic [OUT_W-1:0]         res_data,
  input  logic                     res_ready,
  output logic                     busy
);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {LOAD, SETTLE, HOLD} state_t;
  state_t                   r_state, w_next;
  logic [CNT_W-1:0]         r_k;
  logic [SC_W-1:0]          r_cnt;
  logic [N_FEAT*FEAT_W-1:0] r_inp;
  logic [OUT_W-1:0]         r_res;
  logic                     w_accept, w_last, w_cap, w_take;
  assign w_accept = feat_valid && r_state == LOAD;
  assign w_last   = r_k == CNT_W'(N_FEAT - 1);
  assign w_cap    = r_state == SETTLE && r_cnt == SC_W'(SETTLE_CYCLES - 1);
  assign w_take   = r_state == HOLD && res_ready;
  assign inp      = r_inp;
  assign res_data = r_res;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? LOAD : w_next;
  // next state and handshake outputs, all decoded from registered state
  always_comb begin
    w_next     = (w_accept && w_last) ? SETTLE : w_cap ? HOLD : w_take ? LOAD : r_state;
    feat_ready = r_state == LOAD;
    busy       = r_state != LOAD;
    res_valid  = r_state == HOLD;
  end
  // feature slice writes, settle timer and result capture
  always_ff @(posedge clk)
    if (rst) begin
      r_k   <= '0;
      r_cnt <= '0;
      r_inp <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_inp[r_k*FEAT_W +: FEAT_W] <= feat_data;
        r_k <= w_last ? '0 : r_k + 1'b1;
      end
      r_cnt <= r_state == SETTLE ? r_cnt + 1'b1 : '0;
      if (w_cap) r_res <= mlp_out;
    end
endmodule

// File: doc/mlp_feature_loader.md
Name: mlp_feature_loader

Overview:
- Upstream front-end for the combinational printed MLP regressor with 6 features × 5 bits, 30-bit input vector and 20-bit output.
- Accepts features one at a time over a narrow 5-bit valid/ready stream and assembles them into the 30-bit vector driven on the regressor input.
- Holds that vector stable for a programmable settle time so the slow printed logic can propagate.
- Captures the 20-bit regressor result and offers it downstream on a valid/ready port.

Parameters:
- N_FEAT, 6: features per inference vector.
- FEAT_W, 5: bits per feature.
- OUT_W, 20: regressor result width.
- SETTLE_CYCLES, 4: clock cycles the vector is held before the result is captured; must be ≥1.
- CNT_W, 3: width of the feature index counter; must satisfy 2^CNT_W ≥ N_FEAT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- feat_valid  in  1  feature word present.
- feat_data  in  FEAT_W  unsigned feature value.
- feat_ready  out  1  loader accepts a feature this cycle.
- inp  out  N_FEAT*FEAT_W  assembled feature vector, wired to the regressor input.
- mlp_out  in  OUT_W  regressor combinational output.
- res_valid  out  1  captured result available.
- res_data  out  OUT_W  captured result.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high in SETTLE or HOLD.

Behaviour:
- Reset (rst=1 at an edge):
  - state=LOAD, feature index k=0, settle counter=0.
  - inp=0, res_data=0, res_valid=0.
  - feat_ready=1 and busy=0 from the following cycle.
  - rst has priority over every other input in any state; a partial vector or pending result is discarded.
- feat_ready = (state==LOAD); busy = (state!=LOAD). Both are decoded from registered state; there is no combinational path from feat_valid.
- LOAD state:
  - On an edge with feat_valid&&feat_ready, write feat_data into inp[k*FEAT_W +: FEAT_W] and increment k. Feature 0 lands in the LSBs.
  - The other inp slices keep their previous contents. inp is not cleared between vectors.
  - When the accepted feature has k==N_FEAT-1: k←0, settle counter←0, state←SETTLE.
  - Gaps (feat_valid=0) of any length are allowed; the partial vector is held indefinitely.
- SETTLE state:
  - inp is frozen and feat_data is ignored.
  - The counter increments every cycle.
  - Call the edge that accepted the last feature edge 0. At edge SETTLE_CYCLES, res_data←mlp_out, res_valid←1, state←HOLD.
- HOLD state:
  - res_valid=1; inp and res_data are stable.
  - On an edge with res_valid&&res_ready: res_valid←0, state←LOAD. feat_ready is 1 in the next cycle.
  - res_data keeps its last value after the handshake.
  - res_ready may already be high when res_valid rises; the transfer then completes at the next edge.
- res_valid depends only on state. It never drops without a handshake or reset.
- Arithmetic: k and the settle counter are unsigned. Both wrap only via an explicit reset to 0 at the transitions above and never overflow. No arithmetic is applied to the data paths; they are pure register transfers.
- Throughput: at best, one vector per N_FEAT + SETTLE_CYCLES + 1 cycles.
- mlp_out is sampled only at the single capture edge. Changes on it at any other time have no effect.

Test Plan:
- Reset, then stream features 1,2,3,4,5,6 back-to-back:
  - inp=0x0C520C41 after the 6th edge; feat_ready=0 and busy=1 from the next cycle.
  - With mlp_out tied to a bench value 0x12345, res_valid rises exactly 4 edges after the 6th accept and res_data=0x12345.
- Stream six zero features with the real regressor attached to inp/mlp_out:
  - res_data=3658 (0x00E4A).
  - Hold res_ready=0 for 10 cycles: res_valid stays 1 and res_data stays constant; then pulse res_ready for one cycle: res_valid=0 and feat_ready=1 on the next cycle.
- Insert 3-cycle feat_valid gaps between features 2/3 and 5/6:
  - The same vector is assembled.
  - The SETTLE count starts only after the 6th accept.
- Drive feat_valid=1 with changing feat_data throughout SETTLE and HOLD:
  - inp is unchanged.
  - No extra feature is consumed.
  - The next vector starts at slice 0.
- Assert rst after 3 features have been accepted, and separately while in HOLD:
  - The next cycle shows inp=0, res_valid=0, res_data=0, feat_ready=1.
  - A following full vector is captured correctly.
- res_ready held at 1 continuously across two vectors:
  - res_valid is high for exactly one cycle per vector.
  - Consecutive vectors are spaced 11 cycles apart at full input rate.
